// File: rtl/instruction_decode_stage_if.sv
// Shared decode constants/types and the fetch/execute handshake bundle
// for instruction_decode_stage.
package instruction_decode_stage_pkg;
    localparam int XLEN          = 32;
    localparam int IMM_SEL_WIDTH = 2;

    localparam logic [IMM_SEL_WIDTH:0] IMM_I_TYPE       = 3'd0;
    localparam logic [IMM_SEL_WIDTH:0] IMM_S_TYPE       = 3'd1;
    localparam logic [IMM_SEL_WIDTH:0] IMM_B_TYPE       = 3'd2;
    localparam logic [IMM_SEL_WIDTH:0] IMM_U_TYPE       = 3'd3;
    localparam logic [IMM_SEL_WIDTH:0] IMM_J_TYPE       = 3'd4;
    localparam logic [IMM_SEL_WIDTH:0] IMM_UNKNOWN_TYPE = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [31:0]            instr;
        logic [IMM_SEL_WIDTH:0] imm_sel;
        logic                   imm_en;
        logic                   illegal;
    } id_entry_t;
endpackage

interface instruction_decode_stage_if;
    import instruction_decode_stage_pkg::*;

    logic                   i_Valid;
    logic                   o_Ready;
    logic [31:0]            i_Instruction;
    logic [XLEN-1:0]        i_PC;
    logic                   o_Valid;
    logic                   i_Ready;
    logic [XLEN-1:0]        o_PC;
    logic [31:7]            o_Instruction_No_Opcode;
    logic [6:0]             o_Opcode;
    logic [4:0]             o_Rd;
    logic [4:0]             o_Rs1;
    logic [4:0]             o_Rs2;
    logic [2:0]             o_Funct3;
    logic [6:0]             o_Funct7;
    logic [IMM_SEL_WIDTH:0] o_Imm_Select;
    logic                   o_Imm_Enable;
    logic                   o_Illegal;

    modport master (
        input  i_Valid, i_Instruction, i_PC, i_Ready,
        output o_Ready, o_Valid, o_PC, o_Instruction_No_Opcode,
        output o_Opcode, o_Rd, o_Rs1, o_Rs2, o_Funct3, o_Funct7,
        output o_Imm_Select, o_Imm_Enable, o_Illegal
    );

    modport slave (
        output i_Valid, i_Instruction, i_PC, i_Ready,
        input  o_Ready, o_Valid, o_PC, o_Instruction_No_Opcode,
        input  o_Opcode, o_Rd, o_Rs1, o_Rs2, o_Funct3, o_Funct7,
        input  o_Imm_Select, o_Imm_Enable, o_Illegal
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// Fetch->execute decode pipeline register with optional skid entry.
// Optional feature macro: DECODE_SKID_BUFFER_EN (registered o_Ready).
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
(
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Flush,
    instruction_decode_stage_if.master bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam id_entry_t ENTRY_IDLE = '{
        pc:      '0,
        instr:   '0,
        imm_sel: IMM_UNKNOWN_TYPE,
        imm_en:  1'b0,
        illegal: 1'b0
    };

    function automatic id_entry_t decode(
        input logic [31:0]     instr,
        input logic [XLEN-1:0] pc
    );
        id_entry_t  e;
        logic [6:0] op;
        op        = instr[6:0];
        e.pc      = pc;
        e.instr   = instr;
        e.imm_sel = IMM_UNKNOWN_TYPE;
        e.imm_en  = 1'b1;
        e.illegal = 1'b0;
        unique case (1'b1)
            (op == 7'b0110111),
            (op == 7'b0010111): e.imm_sel = IMM_U_TYPE;
            (op == 7'b1101111): e.imm_sel = IMM_J_TYPE;
            (op == 7'b1100111),
            (op == 7'b0000011),
            (op == 7'b0010011),
            (op == 7'b0001111),
            (op == 7'b1110011): e.imm_sel = IMM_I_TYPE;
            (op == 7'b0100011): e.imm_sel = IMM_S_TYPE;
            (op == 7'b1100011): e.imm_sel = IMM_B_TYPE;
            (op == 7'b0110011): e.imm_en  = 1'b0;
            default: begin
                e.imm_en  = 1'b0;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    state_t    state_q, state_d;
    id_entry_t main_q, main_d;
    id_entry_t in_entry;
    logic      in_fire;
    logic      out_fire;

    assign in_entry = decode(bus.i_Instruction, bus.i_PC);
    assign in_fire  = bus.i_Valid && bus.o_Ready;
    assign out_fire = bus.o_Valid && bus.i_Ready;

    assign bus.o_Valid = (state_q != EMPTY);

`ifdef DECODE_SKID_BUFFER_EN
    id_entry_t skid_q, skid_d;
    logic      ready_q;

    assign bus.o_Ready = ready_q;
`else
    assign bus.o_Ready = !bus.o_Valid || bus.i_Ready;
`endif

    // Next-state and next-payload selection for the main/skid entries.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef DECODE_SKID_BUFFER_EN
        skid_d  = skid_q;
`endif
        if (i_Flush) begin
            state_d = EMPTY;
            main_d  = ENTRY_IDLE;
`ifdef DECODE_SKID_BUFFER_EN
            skid_d  = ENTRY_IDLE;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_entry;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = ENTRY_IDLE;
`ifdef DECODE_SKID_BUFFER_EN
                    end else if (in_fire) begin
                        state_d = SKID;
                        skid_d  = in_entry;
`endif
                    end
                end
                SKID: begin
`ifdef DECODE_SKID_BUFFER_EN
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = ENTRY_IDLE;
                    end
`else
                    state_d = EMPTY;
                    main_d  = ENTRY_IDLE;
`endif
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = ENTRY_IDLE;
                end
            endcase
        end
    end

    // State and payload registers; reset wins over flush and transfers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= EMPTY;
            main_q  <= ENTRY_IDLE;
`ifdef DECODE_SKID_BUFFER_EN
            skid_q  <= ENTRY_IDLE;
            ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef DECODE_SKID_BUFFER_EN
            skid_q  <= skid_d;
            ready_q <= (state_d != SKID);
`endif
        end
    end

    assign bus.o_PC                    = main_q.pc;
    assign bus.o_Instruction_No_Opcode = main_q.instr[31:7];
    assign bus.o_Opcode                = main_q.instr[6:0];
    assign bus.o_Rd                    = main_q.instr[11:7];
    assign bus.o_Rs1                   = main_q.instr[19:15];
    assign bus.o_Rs2                   = main_q.instr[24:20];
    assign bus.o_Funct3                = main_q.instr[14:12];
    assign bus.o_Funct7                = main_q.instr[31:25];
    assign bus.o_Imm_Select            = main_q.imm_sel;
    assign bus.o_Imm_Enable            = main_q.imm_en;
    assign bus.o_Illegal               = main_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Randomised bench for instruction_decode_stage against a queue model,
// plus directed scenarios with hand-computed expectations.
module tb_instruction_decode_stage;
    import instruction_decode_stage_pkg::*;

    logic i_Clock;
    logic i_Reset;
    logic i_Flush;

    instruction_decode_stage_if bus();

    instruction_decode_stage dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Flush (i_Flush),
        .bus     (bus)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

`ifdef DECODE_SKID_BUFFER_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [95:0] a,
                       input logic [95:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference decode written straight from the opcode table.
    function automatic logic [4:0] ref_dec(input logic [31:0] w);
        logic [2:0] sel;
        logic en, ill;
        en  = 1'b1;
        ill = 1'b0;
        sel = IMM_UNKNOWN_TYPE;
        case (w[6:0])
            7'h37, 7'h17:                      sel = IMM_U_TYPE;
            7'h6F:                             sel = IMM_J_TYPE;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: sel = IMM_I_TYPE;
            7'h23:                             sel = IMM_S_TYPE;
            7'h63:                             sel = IMM_B_TYPE;
            7'h33:                             en  = 1'b0;
            default: begin
                en  = 1'b0;
                ill = 1'b1;
            end
        endcase
        return {sel, en, ill};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    txn_t q[$];
    bit   armed = 0;

    // Model check and update, once per cycle away from the active edge.
    always @(negedge i_Clock) begin
        logic        ev;
        logic        er;
        logic [31:0] w;
        logic [31:0] p;
        logic [95:0] exp_v;
        logic [95:0] act_v;
        ev = (q.size() != 0);
        er = SKID_EN ? (q.size() < 2) : (q.size() == 0 || bus.i_Ready);
        if (armed) begin
            chk("o_Valid", {95'd0, bus.o_Valid}, {95'd0, ev});
            chk("o_Ready", {95'd0, bus.o_Ready}, {95'd0, er});
            if (ev) begin
                w     = q[0].instr;
                p     = q[0].pc;
                exp_v = {2'b0, p, w[31:7], w[6:0], w[11:7], w[19:15],
                         w[24:20], w[14:12], w[31:25], ref_dec(w)};
            end else begin
                exp_v = {2'b0, 32'd0, 25'd0, 7'd0, 5'd0, 5'd0, 5'd0,
                         3'd0, 7'd0, IMM_UNKNOWN_TYPE, 2'b00};
            end
            act_v = {2'b0, bus.o_PC, bus.o_Instruction_No_Opcode,
                     bus.o_Opcode, bus.o_Rd, bus.o_Rs1, bus.o_Rs2,
                     bus.o_Funct3, bus.o_Funct7, bus.o_Imm_Select,
                     bus.o_Imm_Enable, bus.o_Illegal};
            chk("payload", act_v, exp_v);
        end
        if (i_Reset) begin
            q.delete();
            armed = 1;
        end else if (armed) begin
            if (i_Flush) begin
                q.delete();
            end else begin
                if (ev && bus.i_Ready) void'(q.pop_front());
                if (bus.i_Valid && er)
                    q.push_back('{instr: bus.i_Instruction, pc: bus.i_PC});
            end
        end
    end

    task automatic step;
        @(posedge i_Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w,
                         input logic [31:0] p);
        bus.i_Valid       = v;
        bus.i_Instruction = w;
        bus.i_PC          = p;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                7'h0F, 7'h73, 7'h23, 7'h63, 7'h33, 7'h00};
        w = $urandom;
        if ($urandom_range(0, 4) != 0)
            w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    initial begin
        drive(1'b0, 32'd0, 32'd0);
        bus.i_Ready = 1'b1;
        i_Flush     = 1'b0;
        i_Reset     = 1'b1;
        step;
        step;
        i_Reset = 1'b0;
        chk("rst_valid", {95'd0, bus.o_Valid}, 96'd0);
        chk("rst_ready", {95'd0, bus.o_Ready}, 96'd1);
        chk("rst_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_UNKNOWN_TYPE});
        chk("rst_pc", {64'd0, bus.o_PC}, 96'd0);

        drive(1'b1, 32'h000010B7, 32'h100);
        step;
        drive(1'b0, 32'd0, 32'd0);
        chk("lui_valid", {95'd0, bus.o_Valid}, 96'd1);
        chk("lui_rd", {91'd0, bus.o_Rd}, 96'd1);
        chk("lui_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_U_TYPE});
        chk("lui_en", {95'd0, bus.o_Imm_Enable}, 96'd1);
        chk("lui_noopc", {71'd0, bus.o_Instruction_No_Opcode}, 96'h21);
        chk("lui_pc", {64'd0, bus.o_PC}, 96'h100);
        step;

        drive(1'b1, 32'hFE010113, 32'h200);
        step;
        chk("addi_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_I_TYPE});
        drive(1'b1, 32'h00112623, 32'h204);
        step;
        chk("sw_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_S_TYPE});
        chk("sw_rs2", {91'd0, bus.o_Rs2}, 96'd1);
        drive(1'b1, 32'hFE0008E3, 32'h208);
        step;
        chk("beq_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_B_TYPE});
        drive(1'b1, 32'h0080006F, 32'h20C);
        step;
        chk("jal_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_J_TYPE});
        chk("jal_valid", {95'd0, bus.o_Valid}, 96'd1);
        drive(1'b0, 32'd0, 32'd0);
        step;
        chk("stream_end", {95'd0, bus.o_Valid}, 96'd0);

        drive(1'b1, 32'h00B50533, 32'h300);
        step;
        chk("add_en", {95'd0, bus.o_Imm_Enable}, 96'd0);
        chk("add_ill", {95'd0, bus.o_Illegal}, 96'd0);
        drive(1'b1, 32'hFFFFFFFF, 32'h304);
        step;
        chk("bad_ill", {95'd0, bus.o_Illegal}, 96'd1);
        chk("bad_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_UNKNOWN_TYPE});
        drive(1'b0, 32'd0, 32'd0);
        step;

        bus.i_Ready = 1'b0;
        drive(1'b1, 32'h00A00093, 32'h400);
        step;
        chk("stall_a", {64'd0, bus.o_PC}, 96'h400);
        drive(1'b1, 32'h00C00113, 32'h404);
        step;
        chk("stall_hold", {64'd0, bus.o_PC}, 96'h400);
        chk("stall_ready", {95'd0, bus.o_Ready}, 96'd0);
        if (SKID_EN) drive(1'b0, 32'd0, 32'd0);
        step;
        chk("stall_hold2", {64'd0, bus.o_PC}, 96'h400);
        bus.i_Ready = 1'b1;
        step;
        chk("stall_b", {64'd0, bus.o_PC}, 96'h404);
        drive(1'b0, 32'd0, 32'd0);
        step;
        chk("stall_drain", {95'd0, bus.o_Valid}, 96'd0);

        bus.i_Ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h500);
        step;
        drive(1'b1, 32'h00200113, 32'h504);
        step;
        drive(1'b1, 32'h00300193, 32'h508);
        i_Flush = 1'b1;
        step;
        i_Flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("flush_valid", {95'd0, bus.o_Valid}, 96'd0);
        chk("flush_pc", {64'd0, bus.o_PC}, 96'd0);
        chk("flush_ready", {95'd0, bus.o_Ready}, 96'd1);
        bus.i_Ready = 1'b1;
        step;
        chk("flush_after", {95'd0, bus.o_Valid}, 96'd0);

        bus.i_Ready = 1'b0;
        drive(1'b1, 32'h00400213, 32'h600);
        step;
        drive(1'b1, 32'h00500293, 32'h604);
        step;
        i_Reset = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        step;
        i_Reset = 1'b0;
        chk("mrst_valid", {95'd0, bus.o_Valid}, 96'd0);
        chk("mrst_pc", {64'd0, bus.o_PC}, 96'd0);
        chk("mrst_rd", {91'd0, bus.o_Rd}, 96'd0);
        chk("mrst_sel", {93'd0, bus.o_Imm_Select}, {93'd0, IMM_UNKNOWN_TYPE});
        chk("mrst_en", {95'd0, bus.o_Imm_Enable}, 96'd0);
        chk("mrst_ready", {95'd0, bus.o_Ready}, 96'd1);
        bus.i_Ready = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom);
            bus.i_Ready = ($urandom_range(0, 9) < 6);
            i_Flush     = ($urandom_range(0, 99) < 3);
            i_Reset     = ($urandom_range(0, 199) < 1);
            step;
        end

        drive(1'b0, 32'd0, 32'd0);
        i_Flush     = 1'b0;
        i_Reset     = 1'b0;
        bus.i_Ready = 1'b1;
        repeat (4) step;
        chk("final_idle", {95'd0, bus.o_Valid}, 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
